pe_oob_cfg_decoder: RTL

- Consumes the OOB configuration stream that the stack interface forwards to PE control (sti__cntl__oob_*).
- Parses multi-beat OOB packets into one PE configuration record: tag, streaming-op opcode, lane-enable mask and operand count.
- Presents the record to the PE control FSM with a valid/ready handshake.
- Back-pressures the stack interface while a record is pending and drops malformed or unknown packets.

---
 rtl/pe_oob_cfg_decoder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pe_oob_cfg_decoder.sv
// pe_oob_cfg_decoder
//   Parses the OOB configuration stream from the stack interface into a
//   single PE configuration record: tag, streaming-op opcode, lane mask and
//   operand count. The record is handed to PE control over a valid/ready
//   handshake. The decoder back-pressures the stack interface while a record
//   is pending. Malformed or unknown packets are discarded.
//
// Optional build macro: PE_OOB_CFG_DEC_ERR_CNT_EN
//   When defined, this adds a saturating 8-bit drop counter
//   (dec__cntl__drop_count) and a synchronous clear input
//   (cntl__dec__drop_count_clr).
//
// Ports:
//   clk, reset_poweron               clock, async active-low reset
//   sti__cntl__oob_cntl/valid/type/data  OOB beat in (01 SOP, 00 MOP, 10 EOP, 11 SOM)
//   cntl__sti__oob_ready             registered beat-accept
//   dec__cntl__cfg_valid/cntl__dec__cfg_ready  record handshake
//   dec__cntl__cfg_tag/op/lane_mask/num_operands  record fields
//   dec__cntl__drop_pulse            one-cycle pulse per discarded packet
module pe_oob_cfg_decoder #(
  parameter int unsigned             OOB_DATA_W    = 32,
  parameter int unsigned             OOB_TYPE_W    = 4,
  parameter int unsigned             NUM_LANES     = 32,
  parameter logic [OOB_TYPE_W-1:0]   CFG_TYPE_STOP = OOB_TYPE_W'(1)
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic [1:0]            sti__cntl__oob_cntl,
  input  logic                  sti__cntl__oob_valid,
  output logic                  cntl__sti__oob_ready,
  input  logic [OOB_TYPE_W-1:0] sti__cntl__oob_type,
  input  logic [OOB_DATA_W-1:0] sti__cntl__oob_data,
  output logic                  dec__cntl__cfg_valid,
  input  logic                  cntl__dec__cfg_ready,
  output logic [7:0]            dec__cntl__cfg_tag,
  output logic [7:0]            dec__cntl__cfg_op,
  output logic [NUM_LANES-1:0]  dec__cntl__cfg_lane_mask,
  output logic [15:0]           dec__cntl__cfg_num_operands,
  output logic                  dec__cntl__drop_pulse
`ifdef PE_OOB_CFG_DEC_ERR_CNT_EN
  ,
  input  logic                  cntl__dec__drop_count_clr,
  output logic [7:0]            dec__cntl__drop_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP, S_HOLD} state_t;

  state_t               r_state, w_next;
  logic [1:0]           r_beat_cnt, w_beat_cnt_nxt;
  logic                 r_ready;
  logic                 r_drop;
  logic                 w_drop, w_ld_hdr, w_ld_mask, w_commit;
  logic                 w_xfer, w_sop, w_mop, w_eop, w_cfg_type;
  logic [7:0]           r_sh_tag, r_sh_op;
  logic [NUM_LANES-1:0] r_sh_mask;
  logic [7:0]           r_tag, r_op;
  logic [NUM_LANES-1:0] r_mask;
  logic [15:0]          r_nops;

  assign w_xfer     = sti__cntl__oob_valid & r_ready;
  assign w_sop      = (sti__cntl__oob_cntl == 2'b01);
  assign w_mop      = (sti__cntl__oob_cntl == 2'b00);
  assign w_eop      = (sti__cntl__oob_cntl == 2'b10);
  assign w_cfg_type = (sti__cntl__oob_type == CFG_TYPE_STOP);

  // State register
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_next         = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_drop         = 1'b0;
    w_ld_hdr       = 1'b0;
    w_ld_mask      = 1'b0;
    w_commit       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (w_sop && w_cfg_type) begin
            w_ld_hdr       = 1'b1;
            w_next         = S_BODY;
            w_beat_cnt_nxt = 2'd1;
          end else if (w_sop) begin
            w_drop = 1'b1;
            w_next = S_DROP;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      S_BODY: begin
        if (w_xfer) begin
          if (w_sop) begin
            // Abandon the current packet and treat this SOP as a fresh start.
            w_drop = 1'b1;
            if (w_cfg_type) begin
              w_ld_hdr       = 1'b1;
              w_beat_cnt_nxt = 2'd1;
            end else begin
              w_next = S_DROP;
            end
          end else if (r_beat_cnt == 2'd1 && w_mop) begin
            w_ld_mask      = 1'b1;
            w_beat_cnt_nxt = 2'd2;
          end else if (r_beat_cnt == 2'd2 && w_eop) begin
            w_commit = 1'b1;
            w_next   = S_HOLD;
          end else begin
            w_drop = 1'b1;
            w_next = w_eop ? S_IDLE : S_DROP;
          end
        end
      end
      S_DROP: begin
        if (w_xfer && w_eop) w_next = S_IDLE;
      end
      S_HOLD: begin
        if (cntl__dec__cfg_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_next != S_BODY) w_beat_cnt_nxt = '0;
  end

  // Output logic
  always_comb begin
    dec__cntl__cfg_valid = (r_state == S_HOLD);
    cntl__sti__oob_ready = r_ready;
    dec__cntl__drop_pulse = r_drop;
  end

  // Header and mask fields are staged in shadow registers and only copied to
  // the visible record on a good EOP, so a truncated packet leaves the
  // previous record intact.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_ready   <= 1'b0;
      r_drop    <= 1'b0;
      r_sh_tag  <= '0;
      r_sh_op   <= '0;
      r_sh_mask <= '0;
      r_tag     <= '0;
      r_op      <= '0;
      r_mask    <= '0;
      r_nops    <= '0;
    end else begin
      r_ready <= (w_next != S_HOLD);
      r_drop  <= w_drop;
      if (w_ld_hdr) begin
        r_sh_tag <= sti__cntl__oob_data[15:8];
        r_sh_op  <= sti__cntl__oob_data[7:0];
      end
      if (w_ld_mask) r_sh_mask <= sti__cntl__oob_data[NUM_LANES-1:0];
      if (w_commit) begin
        r_tag  <= r_sh_tag;
        r_op   <= r_sh_op;
        r_mask <= r_sh_mask;
        r_nops <= sti__cntl__oob_data[15:0];
      end
    end
  end

  assign dec__cntl__cfg_tag          = r_tag;
  assign dec__cntl__cfg_op           = r_op;
  assign dec__cntl__cfg_lane_mask    = r_mask;
  assign dec__cntl__cfg_num_operands = r_nops;

`ifdef PE_OOB_CFG_DEC_ERR_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_drop_cnt <= '0;
    end else if (cntl__dec__drop_count_clr) begin
      r_drop_cnt <= '0;
    end else if (r_drop && r_drop_cnt != 8'hFF) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign dec__cntl__drop_count = r_drop_cnt;
`endif

endmodule
